// File: rtl/logic_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the shared logic unit.
// The master side owns the requesters, the logic unit and the response consumer.
interface logic_arbiter_if #(
  parameter int N = 8
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_a;
  logic [2*N-1:0] req_b;
  logic [3:0]     req_op;

  logic [N-1:0]   lu_a;
  logic [N-1:0]   lu_b;
  logic           lu_s2;
  logic           lu_s3;
  logic [N-1:0]   lu_rl;

  logic           resp_valid;
  logic           resp_ready;
  logic           resp_id;
  logic [N-1:0]   resp_data;

  logic [7:0]     cnt0;
  logic [7:0]     cnt1;

  modport master (
    output req_valid, req_a, req_b, req_op, lu_rl, resp_ready,
    input  req_ready, lu_a, lu_b, lu_s2, lu_s3,
           resp_valid, resp_id, resp_data, cnt0, cnt1
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, lu_rl, resp_ready,
    output req_ready, lu_a, lu_b, lu_s2, lu_s3,
           resp_valid, resp_id, resp_data, cnt0, cnt1
  );
endinterface

// File: rtl/logic_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational logic unit.
// One transaction at a time: accept in IDLE, capture result in EXEC, hold it in RESP.
module logic_arbiter #(
  parameter int N = 8
) (
  input logic         clk,
  input logic         rst_n,
  logic_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           last_grant_q;
  logic [N-1:0]   hold_a_q;
  logic [N-1:0]   hold_b_q;
  logic [1:0]     hold_op_q;
  logic           hold_id_q;
  logic [N-1:0]   resp_data_q;
  logic           resp_id_q;
  logic [7:0]     cnt0_q;
  logic [7:0]     cnt1_q;

  logic           gnt_idx;
  logic [1:0]     req_ready_c;
  logic           accept;
  logic           resp_hs;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic [1:0]     sel_op;

  // Tie goes to the requester that did not win last; last_grant resets to 1 so
  // the first tie after reset favours requester 0.
  always_comb begin
    gnt_idx     = 1'b0;
    req_ready_c = '0;
    if (bus.req_valid == 2'b11) begin
      gnt_idx = ~last_grant_q;
    end else if (bus.req_valid[1]) begin
      gnt_idx = 1'b1;
    end
    if ((state_q == IDLE) && (bus.req_valid != 2'b00)) begin
      req_ready_c[gnt_idx] = 1'b1;
    end
  end

  assign accept  = (state_q == IDLE) && (bus.req_valid != 2'b00);
  assign resp_hs = (state_q == RESP) && bus.resp_ready;

  assign sel_a  = gnt_idx ? bus.req_a[N +: N] : bus.req_a[0 +: N];
  assign sel_b  = gnt_idx ? bus.req_b[N +: N] : bus.req_b[0 +: N];
  assign sel_op = gnt_idx ? bus.req_op[2 +: 2] : bus.req_op[0 +: 2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Holding registers feed the logic unit directly so its inputs only move on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      hold_a_q     <= '0;
      hold_b_q     <= '0;
      hold_op_q    <= '0;
      hold_id_q    <= 1'b0;
    end else if (accept) begin
      last_grant_q <= gnt_idx;
      hold_a_q     <= sel_a;
      hold_b_q     <= sel_b;
      hold_op_q    <= sel_op;
      hold_id_q    <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data_q <= '0;
      resp_id_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      resp_data_q <= bus.lu_rl;
      resp_id_q   <= hold_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (resp_hs) begin
      if (resp_id_q) begin
        cnt1_q <= cnt1_q + 8'd1;
      end else begin
        cnt0_q <= cnt0_q + 8'd1;
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.lu_a       = hold_a_q;
  assign bus.lu_b       = hold_b_q;
  assign bus.lu_s2      = hold_op_q[1];
  assign bus.lu_s3      = hold_op_q[0];
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.cnt0       = cnt0_q;
  assign bus.cnt1       = cnt1_q;

endmodule

// File: tb/tb_logic_arbiter.sv
// Directed and randomized transactions against a transaction-level reference model.
module tb_logic_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic m_last;
  int   m_cnt [2];

  logic_arbiter_if #(.N(8)) bus ();

  logic_arbiter #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_lu(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a ^ b;
      2'b10:   return a | b;
      default: return ~b;
    endcase
  endfunction

  // Shared logic unit lives on the bench side of the interface.
  assign bus.lu_rl = ref_lu(bus.lu_a, bus.lu_b, {bus.lu_s2, bus.lu_s3});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    m_last   = 1'b1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_id", 32'(bus.resp_id), 0);
    check("rst_resp_data", 32'(bus.resp_data), 0);
    check("rst_lu_a", 32'(bus.lu_a), 0);
    check("rst_lu_b", 32'(bus.lu_b), 0);
    check("rst_lu_op", 32'({bus.lu_s2, bus.lu_s3}), 0);
    check("rst_cnt0", 32'(bus.cnt0), 0);
    check("rst_cnt1", 32'(bus.cnt1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge with the arbiter idle; returns at a negedge with it idle again.
  task automatic do_txn(input logic [1:0] v,
                        input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] o0,
                        input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] o1,
                        input int stall);
    logic       g;
    logic [7:0] ea, eb, er;
    logic [1:0] eo;
    bus.req_valid  = v;
    bus.req_a      = {a1, a0};
    bus.req_b      = {b1, b0};
    bus.req_op     = {o1, o0};
    bus.resp_ready = 1'b0;
    #1;
    if (v == 2'b00) begin
      check("noreq_ready", 32'(bus.req_ready), 0);
      check("noreq_rv", 32'(bus.resp_valid), 0);
      @(negedge clk);
      return;
    end
    g  = (v == 2'b11) ? ~m_last : v[1];
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    eo = g ? o1 : o0;
    er = ref_lu(ea, eb, eo);
    check("grant", 32'(bus.req_ready), g ? 2 : 1);
    check("idle_rv", 32'(bus.resp_valid), 0);
    @(negedge clk);
    m_last = g;
    check("exec_ready", 32'(bus.req_ready), 0);
    check("exec_rv", 32'(bus.resp_valid), 0);
    check("exec_lu_a", 32'(bus.lu_a), 32'(ea));
    check("exec_lu_b", 32'(bus.lu_b), 32'(eb));
    check("exec_lu_op", 32'({bus.lu_s2, bus.lu_s3}), 32'(eo));
    @(negedge clk);
    for (int i = 0; i <= stall; i++) begin
      check("resp_valid", 32'(bus.resp_valid), 1);
      check("resp_data", 32'(bus.resp_data), 32'(er));
      check("resp_id", 32'(bus.resp_id), 32'(g));
      check("resp_req_ready", 32'(bus.req_ready), 0);
      check("resp_lu_a", 32'(bus.lu_a), 32'(ea));
      bus.resp_ready = (i == stall);
      @(negedge clk);
    end
    bus.resp_ready = 1'b0;
    m_cnt[g] = (m_cnt[g] + 1) % 256;
    check("post_rv", 32'(bus.resp_valid), 0);
    check("cnt0", 32'(bus.cnt0), 32'(m_cnt[0]));
    check("cnt1", 32'(bus.cnt1), 32'(m_cnt[1]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Single requester 0, AND.
    do_txn(2'b01, 8'hF0, 8'h3C, 2'b00, 8'h00, 8'h00, 2'b00, 0);

    // Fresh tie sequence: XOR vs OR, both always valid.
    do_reset();
    for (int k = 0; k < 4; k++)
      do_txn(2'b11, 8'hAA, 8'h0F, 2'b01, 8'hAA, 8'h0F, 2'b10, 0);

    // Requester 1, NOT B, consumer stalls for four cycles.
    do_txn(2'b10, 8'h00, 8'h00, 2'b00, 8'h33, 8'h5A, 2'b11, 4);

    // Randomized mix including idle cycles and stalls.
    for (int k = 0; k < 150; k++) begin
      do_txn(2'($urandom_range(0, 3)),
             8'($urandom), 8'($urandom), 2'($urandom),
             8'($urandom), 8'($urandom), 2'($urandom),
             int'($urandom_range(0, 2)));
    end

    // Make sure both counters are nonzero before the mid-transaction reset.
    do_txn(2'b01, 8'h11, 8'h22, 2'b10, 8'h00, 8'h00, 2'b00, 0);
    do_txn(2'b10, 8'h00, 8'h00, 2'b00, 8'h44, 8'h55, 2'b01, 0);

    // Reset while in EXEC: transaction abandoned, no response, counters cleared.
    bus.req_valid = 2'b01;
    bus.req_a     = {8'h00, 8'h77};
    bus.req_b     = {8'h00, 8'h99};
    bus.req_op    = 4'b0010;
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 3; k++)
      do_txn(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 0);
    check("post_rst_cnt0", 32'(bus.cnt0), 0);
    do_txn(2'b11, 8'hC3, 8'h0F, 2'b00, 8'h3C, 8'hF0, 2'b10, 0);

    // 256 requester-0 transactions wrap cnt0 back to zero.
    do_reset();
    for (int k = 0; k < 256; k++)
      do_txn(2'b01, 8'($urandom), 8'($urandom), 2'($urandom),
             8'h00, 8'h00, 2'b00, 0);
    check("wrap_cnt0", 32'(bus.cnt0), 0);
    check("wrap_cnt1", 32'(bus.cnt1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
